ovl_fire_collector: RTL and testbench

OVL_FIRE_COLLECTOR -- requirements
Module: ovl_fire_collector

---
 rtl/ovl_fire_collector_if.sv | 21 ++
 rtl/ovl_fire_collector.sv | 180 ++++++++++++++++++
 tb/tb_ovl_fire_collector.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ovl_fire_collector_if.sv
// Event-queue handshake between the fire collector and its consumer.
// master drives evt_valid/evt_id, slave drives evt_ready.
interface ovl_fire_collector_if #(
   parameter int ID_WIDTH = 2
);
   logic                evt_valid;
   logic                evt_ready;
   logic [ID_WIDTH-1:0] evt_id;

   modport master (
      output evt_valid,
      output evt_id,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      output evt_ready
   );
endinterface

// File: rtl/ovl_fire_collector.sv
// Aggregates OVL checker fire pulses: saturating per-checker counters,
// first-failure record and a 4-entry event FIFO with sticky overflow.
// Ports: clk, reset_n (async low), enable, fire[N], clear, rd_sel,
//   rd_count, first_valid, first_id, evt (master), overflow, halted.
// Optional: `OVL_FIRE_TIMESTAMP_EN adds TS_WIDTH and first_ts.
module ovl_fire_collector #(
   parameter int NUM_CHECKERS  = 4,
   parameter int ID_WIDTH      = 2,
   parameter int CNT_WIDTH     = 8,
   parameter int STOP_ON_FIRST = 0
`ifdef OVL_FIRE_TIMESTAMP_EN
   ,
   parameter int TS_WIDTH      = 16
`endif
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [NUM_CHECKERS-1:0] fire,
   input  logic                    clear,
   input  logic [ID_WIDTH-1:0]     rd_sel,
   output logic [CNT_WIDTH-1:0]    rd_count,
   output logic                    first_valid,
   output logic [ID_WIDTH-1:0]     first_id,
   ovl_fire_collector_if.master    evt,
   output logic                    overflow,
   output logic                    halted
`ifdef OVL_FIRE_TIMESTAMP_EN
   ,
   output logic [TS_WIDTH-1:0]     first_ts
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MON,
      S_HALT
   } state_e;

   state_e state_q, state_d;
   logic   accept;

   logic [CNT_WIDTH-1:0]    cnt_q [NUM_CHECKERS];
   logic [ID_WIDTH-1:0]     mem_q [4];
   logic [1:0]              rd_ptr_q, wr_ptr_q;
   logic [2:0]              fcnt_q;
   logic [NUM_CHECKERS-1:0] fire_acc;
   logic [1:0]              n_set, n_push;
   logic [ID_WIDTH-1:0]     id0, id1;
   logic                    many, pop, ovf_set, evt_valid;
   logic [2:0]              space;

`ifdef OVL_FIRE_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] ts_q;
`endif

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // next state: clear wins, halting wins over enable drop
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (enable) state_d = S_MON;
            S_MON: begin
               if ((STOP_ON_FIRST != 0) && (|fire_acc))
                  state_d = S_HALT;
               else if (!enable)
                  state_d = S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // outputs of the FSM
   always_comb begin
      accept = (state_q == S_MON) && !clear;
      halted = (state_q == S_HALT);
   end

   assign fire_acc = accept ? fire : '0;

   // lowest two set indices; anything beyond them is dropped
   always_comb begin
      n_set = 2'd0;
      id0   = '0;
      id1   = '0;
      many  = 1'b0;
      for (int i = 0; i < NUM_CHECKERS; i++) begin
         if (fire_acc[i]) begin
            if (n_set == 2'd0)      id0  = ID_WIDTH'(i);
            else if (n_set == 2'd1) id1  = ID_WIDTH'(i);
            else                    many = 1'b1;
            if (n_set != 2'd2) n_set = n_set + 2'd1;
         end
      end
   end

   // a same-cycle pop frees a slot for the incoming push
   always_comb begin
      evt_valid = (fcnt_q != 3'd0);
      pop       = evt_valid & evt.evt_ready;
      space     = 3'd4 - fcnt_q + {2'b00, pop};
      if ({1'b0, n_set} > space) begin
         n_push  = space[1:0];
         ovf_set = 1'b1;
      end else begin
         n_push  = n_set;
         ovf_set = many;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CHECKERS; i++) cnt_q[i] <= '0;
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         rd_ptr_q    <= 2'd0;
         wr_ptr_q    <= 2'd0;
         fcnt_q      <= 3'd0;
         first_valid <= 1'b0;
         first_id    <= '0;
         overflow    <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < NUM_CHECKERS; i++) cnt_q[i] <= '0;
         rd_ptr_q    <= 2'd0;
         wr_ptr_q    <= 2'd0;
         fcnt_q      <= 3'd0;
         first_valid <= 1'b0;
         first_id    <= '0;
         overflow    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CHECKERS; i++)
            if (fire_acc[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}}))
               cnt_q[i] <= cnt_q[i] + 1'b1;
         if (n_push != 2'd0) mem_q[wr_ptr_q] <= id0;
         if (n_push == 2'd2) mem_q[wr_ptr_q + 2'd1] <= id1;
         wr_ptr_q <= wr_ptr_q + n_push;
         rd_ptr_q <= rd_ptr_q + {1'b0, pop};
         fcnt_q   <= fcnt_q - {2'b00, pop} + {1'b0, n_push};
         if (!first_valid && (|fire_acc)) begin
            first_valid <= 1'b1;
            first_id    <= id0;
         end
         if (ovf_set) overflow <= 1'b1;
      end
   end

`ifdef OVL_FIRE_TIMESTAMP_EN
   // free-running; only reset clears it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts_q <= '0;
      else          ts_q <= ts_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     first_ts <= '0;
      else if (clear)   first_ts <= '0;
      else if (!first_valid && (|fire_acc))
         first_ts <= ts_q;
   end
`endif

   always_comb begin
      rd_count = '0;
      for (int i = 0; i < NUM_CHECKERS; i++)
         if (ID_WIDTH'(i) == rd_sel) rd_count = cnt_q[i];
   end

   assign evt.evt_valid = evt_valid;
   assign evt.evt_id    = evt_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Randomized + directed bench for ovl_fire_collector.
// Instance 0: STOP_ON_FIRST=0, instance 1: STOP_ON_FIRST=1.
module tb_ovl_fire_collector;
   localparam int M_IDLE = 0;
   localparam int M_MON  = 1;
   localparam int M_HALT = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable, clear, ready;
   logic [3:0] fire;
   logic [1:0] rd_sel;

   logic [7:0] rdc [2];
   logic       fv  [2];
   logic [1:0] fid [2];
   logic       ev  [2];
   logic [1:0] eid [2];
   logic       ov  [2];
   logic       h   [2];
`ifdef OVL_FIRE_TIMESTAMP_EN
   logic [15:0] fts [2];
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ovl_fire_collector_if #(.ID_WIDTH(2)) ei0 ();
   ovl_fire_collector_if #(.ID_WIDTH(2)) ei1 ();
   assign ei0.evt_ready = ready;
   assign ei1.evt_ready = ready;
   assign ev[0]  = ei0.evt_valid;
   assign eid[0] = ei0.evt_id;
   assign ev[1]  = ei1.evt_valid;
   assign eid[1] = ei1.evt_id;

   ovl_fire_collector #(.STOP_ON_FIRST(0)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .fire(fire), .clear(clear), .rd_sel(rd_sel),
      .rd_count(rdc[0]), .first_valid(fv[0]),
      .first_id(fid[0]), .evt(ei0),
      .overflow(ov[0]), .halted(h[0])
`ifdef OVL_FIRE_TIMESTAMP_EN
      , .first_ts(fts[0])
`endif
   );

   ovl_fire_collector #(.STOP_ON_FIRST(1)) dut_s (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .fire(fire), .clear(clear), .rd_sel(rd_sel),
      .rd_count(rdc[1]), .first_valid(fv[1]),
      .first_id(fid[1]), .evt(ei1),
      .overflow(ov[1]), .halted(h[1])
`ifdef OVL_FIRE_TIMESTAMP_EN
      , .first_ts(fts[1])
`endif
   );

   // reference model: spec rules with queues and plain arithmetic
   int m_cnt [2][4];
   int m_st  [2];
   bit m_fv  [2];
   int m_fid [2];
   int m_fts [2];
   bit m_ovf [2];
   int m_q   [2][$];
   int m_ts;

   task automatic m_clr(int k);
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      m_st[k]  = M_IDLE;
      m_fv[k]  = 0;
      m_fid[k] = 0;
      m_fts[k] = 0;
      m_ovf[k] = 0;
      m_q[k].delete();
   endtask

   task automatic m_step(int k, bit stop);
      int ids[$];
      bit pop;
      pop = (m_q[k].size() > 0) && ready;
      if (clear) begin
         m_clr(k);
         return;
      end
      if (m_st[k] == M_MON)
         for (int i = 0; i < 4; i++)
            if (fire[i]) begin
               ids.push_back(i);
               if (m_cnt[k][i] < 255) m_cnt[k][i]++;
            end
      if (ids.size() > 0 && !m_fv[k]) begin
         m_fv[k]  = 1;
         m_fid[k] = ids[0];
         m_fts[k] = m_ts;
      end
      if (pop) void'(m_q[k].pop_front());
      for (int j = 0; j < ids.size(); j++)
         if (j >= 2 || m_q[k].size() >= 4) m_ovf[k] = 1;
         else m_q[k].push_back(ids[j]);
      case (m_st[k])
         M_IDLE: if (enable) m_st[k] = M_MON;
         M_MON:
            if (stop && ids.size() > 0) m_st[k] = M_HALT;
            else if (!enable) m_st[k] = M_IDLE;
         default: ;
      endcase
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_clr(0);
         m_clr(1);
         m_ts = 0;
      end else begin
         m_step(0, 1'b0);
         m_step(1, 1'b1);
         m_ts = (m_ts + 1) & 16'hffff;
      end
   end

   task automatic check(string tag, logic [31:0] got,
                        logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rd_count%0d", k), 32'(rdc[k]),
               m_cnt[k][rd_sel]);
         check($sformatf("first_valid%0d", k), 32'(fv[k]),
               32'(m_fv[k]));
         check($sformatf("first_id%0d", k), 32'(fid[k]),
               m_fid[k]);
         check($sformatf("evt_valid%0d", k), 32'(ev[k]),
               32'(m_q[k].size() > 0));
         check($sformatf("evt_id%0d", k), 32'(eid[k]),
               m_q[k].size() > 0 ? m_q[k][0] : 0);
         check($sformatf("overflow%0d", k), 32'(ov[k]),
               32'(m_ovf[k]));
         check($sformatf("halted%0d", k), 32'(h[k]),
               32'(m_st[k] == M_HALT));
`ifdef OVL_FIRE_TIMESTAMP_EN
         check($sformatf("first_ts%0d", k), 32'(fts[k]),
               m_fts[k]);
`endif
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      clear   = 1'b0;
      ready   = 1'b0;
      fire    = 4'd0;
      rd_sel  = 2'd0;
      tick();
      check("rst_evt_valid", 32'(ev[0]), 0);
      check("rst_halted", 32'(h[1]), 0);
      reset_n = 1'b1;

      // single fire on checker 2
      enable = 1'b1;
      tick();
      fire   = 4'b0100;
      rd_sel = 2'd2;
      tick();
      fire = 4'd0;
      check("r28_cnt", 32'(rdc[0]), 1);
      check("r28_fv", 32'(fv[0]), 1);
      check("r28_fid", 32'(fid[0]), 2);
      check("r28_eid", 32'(eid[0]), 2);
      check("r28_ev", 32'(ev[0]), 1);

      // saturation
      clear = 1'b1;
      ready = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      fire   = 4'b0001;
      rd_sel = 2'd0;
      repeat (300) tick();
      fire = 4'd0;
      check("r29_sat", 32'(rdc[0]), 255);

      // fill, pop+push while full, then overflow
      clear = 1'b1;
      ready = 1'b0;
      tick();
      clear = 1'b0;
      tick();
      for (int j = 0; j < 4; j++) begin
         fire = 4'(1 << j);
         tick();
      end
      fire = 4'd0;
      check("r30_full_noovf", 32'(ov[0]), 0);
      ready = 1'b1;
      fire  = 4'b0100;
      tick();
      ready = 1'b0;
      fire  = 4'd0;
      check("r30_popush_noovf", 32'(ov[0]), 0);
      check("r30_head", 32'(eid[0]), 1);
      fire = 4'b0001;
      tick();
      fire = 4'd0;
      check("r30_ovf", 32'(ov[0]), 1);

      // stop on first
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      fire = 4'b0010;
      tick();
      fire = 4'b0001;
      tick();
      fire   = 4'd0;
      rd_sel = 2'd0;
      #1;
      check("r31_halted", 32'(h[1]), 1);
      check("r31_cnt0", 32'(rdc[1]), 0);
      check("r31_fid", 32'(fid[1]), 1);
      enable = 1'b0;
      clear  = 1'b1;
      tick();
      clear = 1'b0;
      check("r31_clr_halted", 32'(h[1]), 0);
      check("r31_clr_fv", 32'(fv[1]), 0);

      // random traffic
      repeat (3000) begin
         enable = ($urandom % 8) != 0;
         fire   = ($urandom % 2) ? 4'($urandom) : 4'd0;
         ready  = 1'($urandom);
         clear  = ($urandom % 64) == 0;
         rd_sel = 2'($urandom);
         tick();
      end

      // async reset mid-burst with three queued events
      clear = 1'b1;
      tick();
      clear  = 1'b0;
      enable = 1'b1;
      ready  = 1'b0;
      rd_sel = 2'd0;
      tick();
      fire = 4'b0011;
      tick();
      fire = 4'b0100;
      tick();
      fire = 4'd0;
      check("r32_pre_ev", 32'(ev[0]), 1);
      #2 reset_n = 1'b0;
      #1;
      check("r32_ev", 32'(ev[0]), 0);
      check("r32_cnt", 32'(rdc[0]), 0);
      check("r32_fv", 32'(fv[0]), 0);
      tick();
      reset_n = 1'b1;

`ifdef OVL_FIRE_TIMESTAMP_EN
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      enable  = 1'b1;
      repeat (37) tick();
      fire = 4'b0001;
      tick();
      fire = 4'd0;
      check("r33_ts", 32'(fts[0]), 37);
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
